commit_queue: RTL and testbench
===============================

Name: commit_queue

Overview:
- Parametrised successor to the single-entry commit handshake controller.
- Sits between the last execute/memory stage and writeback/retire.
- Buffers up to DEPTH committed results in order behind a valid/ready handshake on both sides, and raises a per-accept write enable.
- Adds full-throughput operation (push and pop in one cycle), an optional full-queue pass-through mode, a pipeline flush and an occupancy count.

Parameters:
- DATA_W, 32: payload width in bits (commit packet: pc/rd/result bundle), >=1.
- DEPTH, 4: number of entries; power of two, >=2.
- PASS_FULL, 0: 1 = a full queue still accepts when the head pops in the same cycle (combinational ready_post_i -> ready_pre_o path); 0 = ready_pre_o depends on registered state only.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush; discard all entries.
- valid_pre_i  in  1  upstream has a commit packet.
- ready_pre_o  out  1  queue can accept this cycle.
- data_i  in  DATA_W  upstream payload.
- we_o  out  1  entry accepted this cycle (valid_pre_i && ready_pre_o && !flush_i).
- valid_post_o  out  1  head entry is available downstream.
- ready_post_i  in  1  downstream accepts the head.
- data_o  out  DATA_W  head payload.
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, deassert synchronous to clock): wr_ptr=0, rd_ptr=0, count=0. Outputs go to: valid_post_o=0, count_o=0, ready_pre_o=1 (unless flush_i=1), we_o=0 (valid_pre_i is ignored while reset is high). Storage array is not reset.
- data_o is don't-care while valid_post_o=0.
- push = valid_pre_i && ready_pre_o && !flush_i. we_o equals push, combinationally.
- pop = valid_post_o && ready_post_i && !flush_i.
- Outputs:
  - valid_post_o = (count != 0), registered.
  - data_o = mem[rd_ptr], driven from storage with no combinational path from data_i.
  - Minimum latency from push to valid_post_o is 1 cycle; an empty queue never forwards same-cycle.
- ready_pre_o:
  - PASS_FULL=0: ready_pre_o = (count < DEPTH) && !flush_i.
  - PASS_FULL=1: ready_pre_o = ((count < DEPTH) || pop) && !flush_i.
- On a clock edge:
  - push: mem[wr_ptr] <= data_i; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop:
  - With 0 < count < DEPTH, occupancy holds and order is preserved.
  - At count=DEPTH this is legal only when PASS_FULL=1; the slot freed by the head is written.
- Empty queue with ready_post_i=1: no pop, and count does not underflow.
- Full queue with PASS_FULL=0: ready_pre_o=0 even if ready_post_i=1; push lands one cycle after the pop frees space.
- Flush:
  - flush_i=1 clears wr_ptr, rd_ptr and count at the next edge.
  - It overrides push and pop in that cycle: we_o=0 and ready_pre_o=0.
  - valid_post_o drops the cycle after the flush.
  - valid_post_o may still be 1 during the flush cycle, but no transfer is counted.
- Reset mid-operation: all in-flight entries are lost, with the same end state as a flush but asynchronous.
- Handshake rules:
  - Upstream must hold data_i stable while valid_pre_i=1 and ready_pre_o=0.
  - The queue holds data_o and valid_post_o stable until pop.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count_o is one bit wider so that full and empty are distinguishable.

Test Plan:
- Reset, DEPTH=4, PASS_FULL=0: assert reset mid-cycle -> valid_post_o=0, count_o=0, ready_pre_o=1 immediately, no clock edge needed.
- Fill/drain: push 0xA0..0xA3 with ready_post_i=0 -> we_o high on 4 cycles, count_o 1,2,3,4, ready_pre_o=0 at count 4. Then set ready_post_i=1 -> data_o 0xA0,0xA1,0xA2,0xA3 in order, count_o 3,2,1,0.
- Streaming: valid_pre_i=1 and ready_post_i=1 continuously, data 1..16 -> after first-out latency of 1 cycle, one output per cycle, count_o steady at 1, order 1..16, pointers wrap cleanly 4 times.
- Full + pop, PASS_FULL=0 vs 1: queue full, valid_pre_i=1, ready_post_i=1 -> with 0, ready_pre_o=0 and count 4->3->4 over 2 cycles; with 1, ready_pre_o=1, we_o=1 and count stays 4.
- Flush with 3 entries while push and pop both requested -> we_o=0 and ready_pre_o=0 that cycle; next cycle count_o=0, valid_post_o=0; a subsequent push of 0x55 appears on data_o one cycle later.
- Underflow guard: empty queue, ready_post_i=1 for 5 cycles, no valid_pre_i -> count_o stays 0, valid_post_o stays 0.

Source files
------------

// File: rtl/commit_queue.sv
// In-order commit buffer between execute/memory and writeback: DEPTH entries behind
// valid/ready on both sides, with flush, occupancy count and optional full pass-through.
module commit_queue #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter bit PASS_FULL = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     valid_pre_i,
    output logic                     ready_pre_o,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     we_o,
    output logic                     valid_post_o,
    input  logic                     ready_post_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [PW-1:0]                wr_ptr, rd_ptr;
    logic [CW-1:0]                count;
    logic                         push, pop, space;

    assign pop = (count != '0) && ready_post_i && !flush_i;

    // Pass-through only opens a slot through the pop, so ready never depends on itself.
    generate
        if (PASS_FULL) begin : g_pass
            assign space = (count < FULL_CNT) || pop;
        end else begin : g_nopass
            assign space = (count < FULL_CNT);
        end
    endgenerate

    assign ready_pre_o  = space && !flush_i;
    assign push         = valid_pre_i && ready_pre_o && !reset;
    assign we_o         = push;
    assign valid_post_o = (count != '0);
    assign data_o       = mem[rd_ptr];
    assign count_o      = count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; count gates its visibility.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_i;
    end
endmodule

// File: tb/tb_commit_queue.sv
// Scoreboard bench for commit_queue: two DEPTH=4 instances (PASS_FULL 0 and 1) on shared stimulus.
module tb_commit_queue;
    logic       clock = 1'b0;
    logic       reset, flush_i, valid_pre_i, ready_post_i;
    logic [7:0] data_i;
    logic       r0, r1, we0, we1, v0, v1;
    logic [7:0] d0, d1;
    logic [2:0] c0, c1;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_d;

    always #5 clock = ~clock;

    commit_queue #(.DATA_W(8), .DEPTH(4), .PASS_FULL(1'b0)) dut0 (
        .clock(clock), .reset(reset), .flush_i(flush_i), .valid_pre_i(valid_pre_i),
        .ready_pre_o(r0), .data_i(data_i), .we_o(we0), .valid_post_o(v0),
        .ready_post_i(ready_post_i), .data_o(d0), .count_o(c0));

    commit_queue #(.DATA_W(8), .DEPTH(4), .PASS_FULL(1'b1)) dut1 (
        .clock(clock), .reset(reset), .flush_i(flush_i), .valid_pre_i(valid_pre_i),
        .ready_pre_o(r1), .data_i(data_i), .we_o(we1), .valid_post_o(v1),
        .ready_post_i(ready_post_i), .data_o(d1), .count_o(c1));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        valid_pre_i = 1'b0; ready_post_i = 1'b0; flush_i = 1'b0; data_i = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        tick(); tick();
        reset = 1'b0;
        valid_pre_i = 1'b1; data_i = 8'h11; tick();
        data_i = 8'h22; tick();
        checks++; if (c0 !== 3'd2) $display("FAIL pre_reset_count got %0d want 2", c0); else passes++;
        #2 reset = 1'b1;
        #1;
        checks++; if (v0 !== 1'b0) $display("FAIL reset_valid got %b want 0", v0); else passes++;
        checks++; if (c0 !== 3'd0) $display("FAIL reset_count got %0d want 0", c0); else passes++;
        checks++; if (r0 !== 1'b1) $display("FAIL reset_ready got %b want 1", r0); else passes++;
        checks++; if (we0 !== 1'b0) $display("FAIL reset_we got %b want 0", we0); else passes++;
        tick();
        reset = 1'b0; idle();
        tick();
        checks++; if (c0 !== 3'd0 || c1 !== 3'd0) $display("FAIL post_reset_count got %0d/%0d want 0", c0, c1); else passes++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            valid_pre_i = 1'b1; data_i = 8'hA0 + 8'(i); ready_post_i = 1'b0;
            #1;
            checks++; if (we0 !== 1'b1) $display("FAIL fill_we[%0d] got %b want 1", i, we0); else passes++;
            sb.push_back(data_i);
            tick();
            checks++; if (c0 !== 3'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, c0, i + 1); else passes++;
        end
        #1;
        checks++; if (r0 !== 1'b0 || we0 !== 1'b0) $display("FAIL full_ready got r=%b we=%b want 0/0", r0, we0); else passes++;
        valid_pre_i = 1'b0; ready_post_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_d = sb.pop_front();
            checks++; if (v0 !== 1'b1 || d0 !== exp_d) $display("FAIL drain_data[%0d] got v=%b %h want 1 %h", i, v0, d0, exp_d); else passes++;
            tick();
            checks++; if (c0 !== 3'(3 - i)) $display("FAIL drain_count[%0d] got %0d want %0d", i, c0, 3 - i); else passes++;
        end
        idle();
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 16; k++) begin
            valid_pre_i = 1'b1; ready_post_i = 1'b1; data_i = 8'(k + 1);
            #1;
            checks++; if (we0 !== 1'b1) $display("FAIL stream_we[%0d] got %b want 1", k, we0); else passes++;
            if (k == 0) begin
                checks++; if (v0 !== 1'b0) $display("FAIL stream_no_forward got %b want 0", v0); else passes++;
            end else begin
                exp_d = sb.pop_front();
                checks++; if (v0 !== 1'b1 || d0 !== exp_d) $display("FAIL stream_data[%0d] got v=%b %h want 1 %h", k, v0, d0, exp_d); else passes++;
            end
            sb.push_back(data_i);
            tick();
            checks++; if (c0 !== 3'd1) $display("FAIL stream_count[%0d] got %0d want 1", k, c0); else passes++;
        end
        valid_pre_i = 1'b0;
        #1;
        exp_d = sb.pop_front();
        checks++; if (d0 !== exp_d) $display("FAIL stream_last got %h want %h", d0, exp_d); else passes++;
        tick();
        checks++; if (c0 !== 3'd0) $display("FAIL stream_end_count got %0d want 0", c0); else passes++;
        idle();
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            valid_pre_i = 1'b1; data_i = 8'hB0 + 8'(i);
            sb.push_back(data_i);
            tick();
        end
        checks++; if (c0 !== 3'd4 || c1 !== 3'd4) $display("FAIL fp_full got %0d/%0d want 4", c0, c1); else passes++;
        // Cycle 1: full, push and pop both requested.
        valid_pre_i = 1'b1; data_i = 8'hC0; ready_post_i = 1'b1;
        #1;
        checks++; if (r0 !== 1'b0 || we0 !== 1'b0) $display("FAIL fp0_ready got r=%b we=%b want 0/0", r0, we0); else passes++;
        checks++; if (r1 !== 1'b1 || we1 !== 1'b1) $display("FAIL fp1_ready got r=%b we=%b want 1/1", r1, we1); else passes++;
        exp_d = sb.pop_front();
        checks++; if (d0 !== exp_d || d1 !== exp_d) $display("FAIL fp_head got %h/%h want %h", d0, d1, exp_d); else passes++;
        sb.push_back(data_i);
        tick();
        checks++; if (c0 !== 3'd3 || c1 !== 3'd4) $display("FAIL fp_count1 got %0d/%0d want 3/4", c0, c1); else passes++;
        // Cycle 2: the non-pass instance takes the held packet in the freed slot.
        ready_post_i = 1'b0;
        #1;
        checks++; if (we0 !== 1'b1 || we1 !== 1'b0) $display("FAIL fp_we2 got %b/%b want 1/0", we0, we1); else passes++;
        tick();
        checks++; if (c0 !== 3'd4 || c1 !== 3'd4) $display("FAIL fp_count2 got %0d/%0d want 4/4", c0, c1); else passes++;
        valid_pre_i = 1'b0; ready_post_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_d = sb.pop_front();
            checks++; if (d0 !== exp_d || d1 !== exp_d) $display("FAIL fp_drain[%0d] got %h/%h want %h", i, d0, d1, exp_d); else passes++;
            tick();
        end
        checks++; if (c0 !== 3'd0 || c1 !== 3'd0) $display("FAIL fp_empty got %0d/%0d want 0", c0, c1); else passes++;
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            valid_pre_i = 1'b1; data_i = 8'hD0 + 8'(i);
            sb.push_back(data_i);
            tick();
        end
        valid_pre_i = 1'b1; data_i = 8'hD3; ready_post_i = 1'b1; flush_i = 1'b1;
        #1;
        checks++; if (we0 !== 1'b0 || we1 !== 1'b0) $display("FAIL flush_we got %b/%b want 0", we0, we1); else passes++;
        checks++; if (r0 !== 1'b0 || r1 !== 1'b0) $display("FAIL flush_ready got %b/%b want 0", r0, r1); else passes++;
        tick();
        idle();
        sb.delete();
        #1;
        checks++; if (c0 !== 3'd0 || v0 !== 1'b0) $display("FAIL flush_after got c=%0d v=%b want 0/0", c0, v0); else passes++;
        valid_pre_i = 1'b1; data_i = 8'h55;
        #1;
        checks++; if (we0 !== 1'b1) $display("FAIL flush_repush_we got %b want 1", we0); else passes++;
        sb.push_back(data_i);
        tick();
        valid_pre_i = 1'b0;
        exp_d = sb.pop_front();
        checks++; if (v0 !== 1'b1 || d0 !== exp_d || c0 !== 3'd1) $display("FAIL flush_repush got v=%b %h c=%0d want 1 %h 1", v0, d0, c0, exp_d); else passes++;
        ready_post_i = 1'b1;
        tick();
        checks++; if (c0 !== 3'd0) $display("FAIL flush_final got %0d want 0", c0); else passes++;
        idle();
    endtask

    task automatic test_underflow();
        ready_post_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (c0 !== 3'd0 || v0 !== 1'b0) $display("FAIL underflow[%0d] got c=%0d v=%b want 0/0", i, c0, v0); else passes++;
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_pop();
        test_flush();
        test_underflow();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
